// File: rtl/qoa_pkg.sv
// qoa_pkg -- shared constants and types for the QOA SPI command sequencer.
//   Geometry : LMS_TAPS, SLICE_BYTES, SLICE_SAMPS and the derived counter widths.
//   Opcodes  : OP_HIST, OP_WGT, OP_SLICE, OP_READ, OP_STATUS.
//   STATUS_IDX is the sample index the decoder maps to its status word.
//   state_t  : sequencer FSM states.
package qoa_pkg;

  localparam int LMS_TAPS    = 4;
  localparam int SLICE_BYTES = 8;
  localparam int SLICE_SAMPS = 20;

  // The byte counter must cover the longer of the two payload kinds.
  localparam int CNT_MAX = (2 * LMS_TAPS > SLICE_BYTES) ? 2 * LMS_TAPS : SLICE_BYTES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(LMS_TAPS);
  localparam int SLICE_W = 8 * SLICE_BYTES;

  localparam logic [7:0] OP_HIST   = 8'h01;
  localparam logic [7:0] OP_WGT    = 8'h02;
  localparam logic [7:0] OP_SLICE  = 8'h03;
  localparam logic [7:0] OP_READ   = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h0F;

  localparam logic [4:0] STATUS_IDX = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LMS,
    S_SLICE,
    S_WAIT,
    S_READ,
    S_STATUS,
    S_ERR
  } state_t;

endpackage

// File: rtl/qoa_byte_assembler.sv
// qoa_byte_assembler -- collects payload bytes into a big-endian word.
//   sclk, rst_n : clock, synchronous active-low reset
//   clr         : restart the byte count (held while no payload is expected)
//   byte_valid  : byte_in is a payload byte this cycle
//   byte_in     : payload byte
//   limit       : number of bytes that completes the current word
//   word        : assembled word including byte_in, first byte in the MSBs
//   pair_idx    : index of the byte pair the current byte belongs to
//   pair_done   : byte_in is the second byte of a pair
//   word_done   : byte_in is the last byte of the word
module qoa_byte_assembler #(
  parameter int WORD_BYTES = 8,
  parameter int CNT_W      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_in,
  input  logic [CNT_W-1:0]        limit,
  output logic [8*WORD_BYTES-1:0] word,
  output logic [IDX_W-1:0]        pair_idx,
  output logic                    pair_done,
  output logic                    word_done
);

  // Only the bytes that can still be shifted up are stored; the newest byte
  // is appended combinationally so consumers see the full word on the
  // completing cycle.
  logic [8*WORD_BYTES-9:0] shreg;
  logic [CNT_W-1:0]        cnt;

  assign word      = {shreg, byte_in};
  assign pair_done = byte_valid && cnt[0];
  assign word_done = byte_valid && (cnt == limit - CNT_W'(1));
  assign pair_idx  = cnt[IDX_W:1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (byte_valid) begin
      shreg <= word[8*WORD_BYTES-9:0];
      cnt   <= word_done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qoa_cmd_sequencer.sv
// qoa_cmd_sequencer -- SPI-domain command parser feeding the QOA decoder.
//   sclk, rst_n      : SPI clock, synchronous active-low reset
//   cs_n             : chip select, high = deselected; aborts partial commands
//   rx_valid,rx_byte : one-cycle strobe with a received byte
//   lms_we/sel/idx/data : LMS history (sel=0) / weight (sel=1) entry writes
//   slice_req/data, slice_ack : 64-bit slice handoff, held until acknowledged
//   samp_idx, tx_load : sample selection and TX shifter reload strobe
//   err              : sticky protocol error, cleared while cs_n is high
// Build option: QOA_SEQ_STATUS_EN enables opcode 0x0F (STATUS), which loads
// the TX shifter with samp_idx forced to STATUS_IDX for one cycle.
module qoa_cmd_sequencer
  import qoa_pkg::*;
(
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        lms_we,
  output logic        lms_sel,
  output logic [1:0]  lms_idx,
  output logic [15:0] lms_data,
  output logic        slice_req,
  output logic [63:0] slice_data,
  input  logic        slice_ack,
  output logic [4:0]  samp_idx,
  output logic        tx_load,
  output logic        err
);

  state_t state, state_nxt;

  logic             byte_ok;
  logic             in_payload;
  logic             pend_err;   // opcode seen while waiting for slice_ack
  logic [4:0]       samp_q;
  logic [CNT_W-1:0] asm_limit;
  logic [SLICE_W-1:0] asm_word;
  logic [IDX_W-1:0] asm_pair_idx;
  logic             asm_pair_done;
  logic             asm_word_done;

  // A byte that arrives together with cs_n high is dropped.
  assign byte_ok    = rx_valid && !cs_n;
  assign in_payload = (state == S_LMS) || (state == S_SLICE);
  assign asm_limit  = (state == S_LMS) ? CNT_W'(2 * LMS_TAPS) : CNT_W'(SLICE_BYTES);

  qoa_byte_assembler #(
    .WORD_BYTES (SLICE_BYTES),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_asm (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .clr        (!in_payload),
    .byte_valid (byte_ok && in_payload),
    .byte_in    (rx_byte),
    .limit      (asm_limit),
    .word       (asm_word),
    .pair_idx   (asm_pair_idx),
    .pair_done  (asm_pair_done),
    .word_done  (asm_word_done)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    tx_load   = (state == S_READ) || (state == S_STATUS);
    slice_req = (state == S_WAIT);
    samp_idx  = samp_q;
`ifdef QOA_SEQ_STATUS_EN
    if (state == S_STATUS) samp_idx = STATUS_IDX;
`endif
    unique case (state)
      S_IDLE: begin
        if (byte_ok) begin
          case (rx_byte)
            OP_HIST, OP_WGT: state_nxt = S_LMS;
            OP_SLICE:        state_nxt = S_SLICE;
            OP_READ:         state_nxt = S_READ;
`ifdef QOA_SEQ_STATUS_EN
            OP_STATUS:       state_nxt = S_STATUS;
`endif
            default:         state_nxt = S_ERR;
          endcase
        end
      end
      S_LMS:   if (cs_n || asm_word_done) state_nxt = S_IDLE;
      S_SLICE: begin
        if (cs_n)               state_nxt = S_IDLE;
        else if (asm_word_done) state_nxt = S_WAIT;
      end
      // cs_n does not abort a slice handoff; the decoder still gets it.
      S_WAIT:  if (slice_ack) state_nxt = (pend_err || byte_ok) ? S_ERR : S_IDLE;
      S_ERR:   if (cs_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;  // READ / STATUS last one cycle
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      lms_we     <= 1'b0;
      lms_sel    <= 1'b0;
      lms_idx    <= '0;
      lms_data   <= '0;
      slice_data <= '0;
      samp_q     <= '0;
      err        <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      lms_we <= 1'b0;

      if (state == S_IDLE && byte_ok && (rx_byte == OP_HIST || rx_byte == OP_WGT))
        lms_sel <= (rx_byte == OP_WGT);

      if (state == S_LMS && asm_pair_done) begin
        lms_we   <= 1'b1;
        lms_idx  <= asm_pair_idx;
        lms_data <= asm_word[15:0];
      end

      if (state == S_SLICE && asm_word_done) slice_data <= asm_word;

      if (state == S_READ)
        samp_q <= (samp_q == 5'(SLICE_SAMPS - 1)) ? '0 : samp_q + 5'd1;
      else if (state == S_WAIT && slice_ack)
        samp_q <= '0;

      if (cs_n)
        err <= 1'b0;
      else if (state_nxt == S_ERR || (state == S_WAIT && byte_ok))
        err <= 1'b1;

      if (state != S_WAIT || cs_n) pend_err <= 1'b0;
      else if (byte_ok)            pend_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qoa_cmd_sequencer.sv
// tb_qoa_cmd_sequencer -- self-checking bench for qoa_cmd_sequencer.
// A command-level model predicts the LMS writes, slice handoffs, TX loads and
// error flag for each chip-select window; a monitor records what the DUT
// produced and the two event lists are compared at the end of each window.
// Honours QOA_SEQ_STATUS_EN the same way the design does.
module tb_qoa_cmd_sequencer;
  import qoa_pkg::*;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        lms_we;
  logic        lms_sel;
  logic [1:0]  lms_idx;
  logic [15:0] lms_data;
  logic        slice_req;
  logic [63:0] slice_data;
  logic        slice_ack;
  logic [4:0]  samp_idx;
  logic        tx_load;
  logic        err;

  qoa_cmd_sequencer dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .lms_we     (lms_we),
    .lms_sel    (lms_sel),
    .lms_idx    (lms_idx),
    .lms_data   (lms_data),
    .slice_req  (slice_req),
    .slice_data (slice_data),
    .slice_ack  (slice_ack),
    .samp_idx   (samp_idx),
    .tx_load    (tx_load),
    .err        (err)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Event lists: {sel, idx, data} for LMS writes, samp_idx for TX loads.
  logic [18:0] exp_lms[$], act_lms[$];
  logic [4:0]  exp_tx[$],  act_tx[$];
  logic [63:0] exp_sl[$],  act_sl[$];

  // Command-level model state.
  int m_samp = 0;
  bit m_err  = 0;

  logic prev_req = 1'b0;
  always @(negedge sclk) begin
    if (rst_n) begin
      if (lms_we)                act_lms.push_back({lms_sel, lms_idx, lms_data});
      if (tx_load)               act_tx.push_back(samp_idx);
      if (slice_req && !prev_req) act_sl.push_back(slice_data);
    end
    prev_req = slice_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int rgap();
    return $urandom_range(1, 3);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge sclk);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    repeat (gap) @(negedge sclk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    @(negedge sclk);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (3) @(negedge sclk);
  endtask

  task automatic compare_events(input string tag);
    check({tag, ".lms_count"}, 64'(act_lms.size()), 64'(exp_lms.size()));
    for (int i = 0; i < exp_lms.size() && i < act_lms.size(); i++)
      check($sformatf("%s.lms[%0d]", tag, i), 64'(act_lms[i]), 64'(exp_lms[i]));
    check({tag, ".tx_count"}, 64'(act_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++)
      check($sformatf("%s.tx[%0d]", tag, i), 64'(act_tx[i]), 64'(exp_tx[i]));
    check({tag, ".slice_count"}, 64'(act_sl.size()), 64'(exp_sl.size()));
    for (int i = 0; i < exp_sl.size() && i < act_sl.size(); i++)
      check($sformatf("%s.slice[%0d]", tag, i), act_sl[i], exp_sl[i]);
    exp_lms.delete(); act_lms.delete();
    exp_tx.delete();  act_tx.delete();
    exp_sl.delete();  act_sl.delete();
  endtask

  // Closes a window: err must reflect the model, then clear with cs_n high.
  task automatic end_window(input string tag);
    check({tag, ".err"}, 64'(err), 64'(m_err));
    cs_high();
    check({tag, ".err_cleared"}, 64'(err), 64'd0);
    m_err = 0;
    compare_events(tag);
  endtask

  // LMS load with n payload bytes (n < 8 only as the last command of a window).
  task automatic run_lms(input logic wgt, input logic [7:0] pl[8], input int n);
    send_byte(wgt ? OP_WGT : OP_HIST, rgap());
    for (int i = 0; i < n; i++) send_byte(pl[i], rgap());
    for (int p = 0; p < n / 2; p++)
      exp_lms.push_back({wgt, 2'(p), pl[2*p], pl[2*p+1]});
  endtask

  // Acknowledge a pending slice after d cycles and check the handshake.
  task automatic deliver(input int d);
    int guard = 0;
    int held  = 0;
    bit stable = 1;
    logic [63:0] snap;
    while (!slice_req && guard < 8) begin
      @(negedge sclk);
      guard++;
    end
    check("slice_req_seen", 64'(slice_req), 64'd1);
    if (!slice_req) return;
    snap = slice_data;
    while (slice_req && held < 100) begin
      held++;
      if (slice_data !== snap) stable = 0;
      if (held == d) slice_ack = 1'b1;
      @(negedge sclk);
    end
    slice_ack = 1'b0;
    check("slice_req_held", 64'(held), 64'(d));
    check("slice_data_stable", 64'(stable), 64'd1);
    check("samp_idx_after_ack", 64'(samp_idx), 64'd0);
  endtask

  task automatic run_slice(input logic [7:0] pl[8], input int n, input int d);
    logic [63:0] w = '0;
    send_byte(OP_SLICE, rgap());
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i], (i == 7) ? 0 : rgap());
      w = {w[55:0], pl[i]};
    end
    if (n == 8) begin
      exp_sl.push_back(w);
      deliver(d);
      m_samp = 0;
    end
  endtask

  task automatic run_read();
    send_byte(OP_READ, rgap());
    exp_tx.push_back(5'(m_samp));
    m_samp = (m_samp + 1) % SLICE_SAMPS;
  endtask

  // Illegal opcode followed by a few bytes that must all be ignored.
  task automatic run_illegal(input logic [7:0] op);
    send_byte(op, rgap());
    m_err = 1;
    repeat ($urandom_range(0, 3)) send_byte(($urandom_range(0, 1) != 0) ? OP_READ : 8'($urandom), rgap());
  endtask

  task automatic run_status();
`ifdef QOA_SEQ_STATUS_EN
    send_byte(OP_STATUS, rgap());
    exp_tx.push_back(STATUS_IDX);
`else
    run_illegal(OP_STATUS);
`endif
  endtask

  function automatic logic [7:0] pick_illegal();
    logic [7:0] op;
    do begin
      op = 8'($urandom);
    end while (op inside {OP_HIST, OP_WGT, OP_SLICE, OP_READ}
`ifdef QOA_SEQ_STATUS_EN
               || op == OP_STATUS
`endif
              );
    return op;
  endfunction

  logic [7:0] pl[8];

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = '0; slice_ack = 1'b0;
    repeat (3) @(negedge sclk);
    check("rst.lms_we", 64'(lms_we), 64'd0);
    check("rst.lms_sel", 64'(lms_sel), 64'd0);
    check("rst.lms_idx", 64'(lms_idx), 64'd0);
    check("rst.lms_data", 64'(lms_data), 64'd0);
    check("rst.slice_req", 64'(slice_req), 64'd0);
    check("rst.slice_data", slice_data, 64'd0);
    check("rst.samp_idx", 64'(samp_idx), 64'd0);
    check("rst.tx_load", 64'(tx_load), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge sclk);

    // Case 1: history load with signed/boundary values.
    cs_low();
    pl = '{8'h00, 8'h10, 8'hFF, 8'hF0, 8'h12, 8'h34, 8'h80, 8'h00};
    run_lms(1'b0, pl, 8);
    end_window("case1");

    // Case 2 + 3: slice with ack after 5 cycles, then 21 reads wrap the index.
    cs_low();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_slice(pl, 8, 5);
    for (int i = 0; i < 21; i++) run_read();
    end_window("case2_3");

    // Case 4: half a pair aborted by cs_n, then a full weight load.
    cs_low();
    pl = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_lms(1'b1, pl, 1);
    end_window("case4a");
    cs_low();
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    run_lms(1'b1, pl, 8);
    end_window("case4b");

    // Case 5: illegal opcode, cleared by cs_n, then a read works again.
    cs_low();
    run_illegal(8'h7E);
    end_window("case5a");
    cs_low();
    run_read();
    end_window("case5b");

    // Case 6: STATUS opcode, then a read shows samp_idx was not disturbed.
    cs_low();
    run_status();
    if (!m_err) run_read();
    end_window("case6");

    // Last LSB byte arriving with cs_n rising is dropped: only 3 writes.
    cs_low();
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    run_lms(1'b0, pl, 7);
    rx_valid = 1'b1; rx_byte = pl[7]; cs_n = 1'b1;
    @(negedge sclk);
    rx_valid = 1'b0;
    repeat (3) @(negedge sclk);
    check("drop.err", 64'(err), 64'd0);
    compare_events("drop");

    // Opcode during slice wait: slice still delivered, err immediate, then ERR.
    cs_low();
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    send_byte(OP_SLICE, rgap());
    for (int i = 0; i < 8; i++) send_byte(pl[i], (i == 7) ? 0 : rgap());
    exp_sl.push_back({pl[0], pl[1], pl[2], pl[3], pl[4], pl[5], pl[6], pl[7]});
    send_byte(OP_READ, 0);
    check("wait_op.err", 64'(err), 64'd1);
    check("wait_op.req_held", 64'(slice_req), 64'd1);
    slice_ack = 1'b1;
    @(negedge sclk);
    slice_ack = 1'b0;
    check("wait_op.req_dropped", 64'(slice_req), 64'd0);
    m_samp = 0;
    m_err  = 1;
    send_byte(OP_READ, rgap());   // ignored in ERR
    end_window("wait_op");

    // Reset while a slice is pending drops it and restores reset values.
    cs_low();
    run_read();
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    send_byte(OP_SLICE, rgap());
    for (int i = 0; i < 8; i++) send_byte(pl[i], (i == 7) ? 0 : rgap());
    check("mid_rst.req_before", 64'(slice_req), 64'd1);
    rst_n = 1'b0;
    @(negedge sclk);
    check("mid_rst.slice_req", 64'(slice_req), 64'd0);
    check("mid_rst.slice_data", slice_data, 64'd0);
    check("mid_rst.samp_idx", 64'(samp_idx), 64'd0);
    rst_n = 1'b1;
    cs_n  = 1'b1;
    m_samp = 0;
    exp_lms.delete(); act_lms.delete();
    exp_tx.delete();  act_tx.delete();
    exp_sl.delete();  act_sl.delete();
    repeat (2) @(negedge sclk);

    // Randomised windows of mixed commands; the last one may be truncated.
    for (int w = 0; w < 40; w++) begin
      int ncmd = $urandom_range(1, 4);
      cs_low();
      for (int c = 0; c < ncmd && !m_err; c++) begin
        bit last = (c == ncmd - 1);
        int k    = $urandom_range(0, 9);
        int n    = (last && $urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 8;
        for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
        case (k)
          0, 1:    run_lms(1'b0, pl, n);
          2, 3:    run_lms(1'b1, pl, n);
          4, 5:    run_slice(pl, n, $urandom_range(1, 6));
          6, 7:    run_read();
          8:       run_status();
          default: run_illegal(pick_illegal());
        endcase
      end
      end_window($sformatf("rand%0d", w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
